// File: rtl/intl_axim_req_if.sv
// ----------------------------------------------------------------------------
// intl_axim_req_if
// AXI4-Lite master-side bundle used by intl_axim_req. Only the channels the
// requester needs are present; AWPROT/ARPROT are tied off in the interconnect.
//
// Modports
//   master : requester side (drives addr/data/valid, bready/rready)
//   slave  : register-slave side (drives ready, responses, read data)
// ----------------------------------------------------------------------------
interface intl_axim_req_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
    logic                    m_axi_awvalid;
    logic                    m_axi_awready;
    logic [DATA_WIDTH-1:0]   m_axi_wdata;
    logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
    logic                    m_axi_wvalid;
    logic                    m_axi_wready;
    logic [1:0]              m_axi_bresp;
    logic                    m_axi_bvalid;
    logic                    m_axi_bready;
    logic [ADDR_WIDTH-1:0]   m_axi_araddr;
    logic                    m_axi_arvalid;
    logic                    m_axi_arready;
    logic [DATA_WIDTH-1:0]   m_axi_rdata;
    logic [1:0]              m_axi_rresp;
    logic                    m_axi_rvalid;
    logic                    m_axi_rready;

    modport master (
        output m_axi_awaddr, m_axi_awvalid, input m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid, input m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid, output m_axi_bready,
        output m_axi_araddr, m_axi_arvalid, input m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid, output m_axi_rready
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awvalid, output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid, output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid, input m_axi_bready,
        input  m_axi_araddr, m_axi_arvalid, output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid, input m_axi_rready
    );
endinterface

// File: rtl/intl_axim_req.sv
// ----------------------------------------------------------------------------
// intl_axim_req
// Single-outstanding AXI4-Lite master: turns a simple request strobe into one
// AXI4-Lite write (AW+W, then B) or read (AR, then R) and reports the result
// with a one-cycle response pulse.
//
// Ports
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_req_valid/o_req_ready  request handshake (ready only in IDLE)
//   i_req_wr/addr/wdata      request direction, byte address, write data
//   o_rsp_valid              one-cycle completion pulse
//   o_rsp_rdata/resp         read data (0 for writes) and BRESP/RRESP, held
//   o_rsp_timeout            transaction aborted by timeout
//   axi                      AXI4-Lite master bundle (intl_axim_req_if.master)
//
// Optional feature: define INTL_AXIM_TIMEOUT_EN to abort a transaction that
// has spent TIMEOUT_CYCLES cycles waiting on the slave.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready for a request
// S_WADDR | AW and W offered, each dropped after its own handshake
// S_BRESP | waiting for write response
// S_RADDR | AR offered
// S_RDATA | waiting for read data
// S_RSP   | one-cycle completion pulse
// ----------------------------------------------------------------------------
module intl_axim_req #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 7,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_req_valid,
    output logic                          o_req_ready,
    input  logic                          i_req_wr,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_req_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] i_req_wdata,
    output logic                          o_rsp_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0] o_rsp_rdata,
    output logic [1:0]                    o_rsp_resp,
    output logic                          o_rsp_timeout,
    intl_axim_req_if.master               axi
);
    typedef enum logic [2:0] {
        S_IDLE, S_WADDR, S_BRESP, S_RADDR, S_RDATA, S_RSP
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0] r_wdata;
    logic                          r_aw_pend;
    logic                          r_w_pend;
    logic [C_M_AXI_DATA_WIDTH-1:0] r_rsp_rdata;
    logic [1:0]                    r_rsp_resp;
    logic                          r_rsp_tmo;
    logic                          w_accept;
    logic                          w_tc;
    logic                          w_tmo_fire;

    assign w_accept = i_req_valid & o_req_ready;

    assign axi.m_axi_awaddr = r_addr;
    assign axi.m_axi_araddr = r_addr;
    assign axi.m_axi_wdata  = r_wdata;
    assign axi.m_axi_wstrb  = 4'b1111;

    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_resp    = r_rsp_resp;
    assign o_rsp_timeout = r_rsp_tmo;

`ifdef INTL_AXIM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo_cnt;
    logic          w_busy;

    assign w_busy = (r_state == S_WADDR) || (r_state == S_BRESP) ||
                    (r_state == S_RADDR) || (r_state == S_RDATA);

    // Loaded so that terminal count is seen on the TIMEOUT_CYCLES-th
    // waiting cycle; the abort then takes effect at the following edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
        end else if (w_busy && (r_tmo_cnt != '0)) begin
            r_tmo_cnt <= r_tmo_cnt - 1'b1;
        end
    end

    assign w_tc = (r_tmo_cnt == '0);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
    assign w_tc         = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_aw_pend   <= 1'b0;
            r_w_pend    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
            r_rsp_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr    <= i_req_addr;
                r_wdata   <= i_req_wdata;
                r_aw_pend <= i_req_wr;
                r_w_pend  <= i_req_wr;
            end
            if (r_state == S_WADDR) begin
                if (axi.m_axi_awready || w_tmo_fire) r_aw_pend <= 1'b0;
                if (axi.m_axi_wready  || w_tmo_fire) r_w_pend  <= 1'b0;
            end
            if ((r_state == S_BRESP) && axi.m_axi_bvalid) begin
                r_rsp_resp  <= axi.m_axi_bresp;
                r_rsp_rdata <= '0;
                r_rsp_tmo   <= 1'b0;
            end
            if ((r_state == S_RDATA) && axi.m_axi_rvalid) begin
                r_rsp_resp  <= axi.m_axi_rresp;
                r_rsp_rdata <= axi.m_axi_rdata;
                r_rsp_tmo   <= 1'b0;
            end
            if (w_tmo_fire) begin
                r_rsp_resp  <= 2'b10;
                r_rsp_rdata <= '0;
                r_rsp_tmo   <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_tmo_fire        = 1'b0;
        o_req_ready       = 1'b0;
        o_rsp_valid       = 1'b0;
        axi.m_axi_awvalid = 1'b0;
        axi.m_axi_wvalid  = 1'b0;
        axi.m_axi_bready  = 1'b0;
        axi.m_axi_arvalid = 1'b0;
        axi.m_axi_rready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Held low while reset is asserted so nothing is accepted.
                o_req_ready = ~i_rst;
                if (i_req_valid && !i_rst) begin
                    w_state_nxt = i_req_wr ? S_WADDR : S_RADDR;
                end
            end
            S_WADDR: begin
                axi.m_axi_awvalid = r_aw_pend;
                axi.m_axi_wvalid  = r_w_pend;
                if ((!r_aw_pend || axi.m_axi_awready) &&
                    (!r_w_pend  || axi.m_axi_wready)) begin
                    w_state_nxt = S_BRESP;
                end else if (w_tc) begin
                    w_state_nxt = S_RSP;
                    w_tmo_fire  = 1'b1;
                end
            end
            S_BRESP: begin
                axi.m_axi_bready = 1'b1;
                if (axi.m_axi_bvalid) begin
                    w_state_nxt = S_RSP;
                end else if (w_tc) begin
                    w_state_nxt = S_RSP;
                    w_tmo_fire  = 1'b1;
                end
            end
            S_RADDR: begin
                axi.m_axi_arvalid = 1'b1;
                if (axi.m_axi_arready) begin
                    w_state_nxt = S_RDATA;
                end else if (w_tc) begin
                    w_state_nxt = S_RSP;
                    w_tmo_fire  = 1'b1;
                end
            end
            S_RDATA: begin
                axi.m_axi_rready = 1'b1;
                if (axi.m_axi_rvalid) begin
                    w_state_nxt = S_RSP;
                end else if (w_tc) begin
                    w_state_nxt = S_RSP;
                    w_tmo_fire  = 1'b1;
                end
            end
            S_RSP: begin
                o_rsp_valid = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_intl_axim_req.sv
// ----------------------------------------------------------------------------
// tb_intl_axim_req
// Bench for intl_axim_req. Each transaction is described by the cycle (counted
// from the acceptance cycle) at which each slave ready/valid first goes high;
// the expected response cycle and payload follow from the handshake rules.
// Build with INTL_AXIM_TIMEOUT_EN to add the timeout case (TIMEOUT_CYCLES=16).
// ----------------------------------------------------------------------------
module tb_intl_axim_req;
`ifdef INTL_AXIM_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_wr;
    logic [6:0]  i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_resp;
    logic        o_rsp_timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    intl_axim_req_if #(.ADDR_WIDTH(7), .DATA_WIDTH(32)) axi ();

    intl_axim_req #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(7),
        .TIMEOUT_CYCLES(TMO)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_wr     (i_req_wr),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_resp   (o_rsp_resp),
        .o_rsp_timeout(o_rsp_timeout),
        .axi          (axi.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [4:0] axi_ctl();
        return {axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_bready,
                axi.m_axi_arvalid, axi.m_axi_rready};
    endfunction

    task automatic slave_idle();
        axi.m_axi_awready = 1'b0;
        axi.m_axi_wready  = 1'b0;
        axi.m_axi_bvalid  = 1'b0;
        axi.m_axi_bresp   = 2'b00;
        axi.m_axi_arready = 1'b0;
        axi.m_axi_rvalid  = 1'b0;
        axi.m_axi_rresp   = 2'b00;
        axi.m_axi_rdata   = 32'h0;
    endtask

    // ta: cycle awready/arready first high; tw: cycle wready first high;
    // tr: earliest cycle bvalid/rvalid may go high (only after address phase).
    task automatic run_txn(input bit wr, input logic [6:0] addr, input logic [31:0] wdata,
                           input int ta, input int tw, input int tr,
                           input logic [1:0] resp, input logic [31:0] rdata,
                           input int rst_at, input bit exp_tmo);
        int          exp_rsp, k_end, c_a, c_w, c_1, c_b;
        int          rsp_k = -1, n_rsp = 0, n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
        bit          aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0, drop = 0;
        logic        prev_awv = 0, prev_wv = 0, prev_arv = 0;
        logic        rdy_end = 0, bready_rsp = 1;
        logic [31:0] got_rdata = '0, got_wdata = '0;
        logic [1:0]  got_resp = '0;
        logic        got_tmo = 0;
        logic [6:0]  got_awaddr = '0, got_araddr = '0;
        logic [3:0]  got_wstrb = '0;

        c_a = imax(1, ta);
        if (wr) begin
            c_w = imax(1, tw);
            c_1 = imax(c_a, c_w);
            c_b = imax(c_1 + 1, tr);
        end else begin
            c_b = imax(c_a + 1, tr);
        end
        exp_rsp = exp_tmo ? TMO + 1 : c_b + 1;
        k_end   = (rst_at >= 0) ? rst_at + 1 : exp_rsp + 1;

        for (int k = 0; k <= k_end; k++) begin
            @(negedge clk);
            i_req_valid = (k == 0);
            i_req_wr    = wr;
            i_req_addr  = addr;
            i_req_wdata = wdata;
            i_rst       = (k == rst_at);
            axi.m_axi_awready = (k >= ta);
            axi.m_axi_wready  = (k >= tw);
            axi.m_axi_arready = (k >= ta);
            axi.m_axi_bvalid  = (k >= tr) && aw_d && w_d && !b_d;
            axi.m_axi_bresp   = resp;
            axi.m_axi_rvalid  = (k >= tr) && ar_d && !r_d;
            axi.m_axi_rresp   = resp;
            axi.m_axi_rdata   = rdata;
            #1;
            if (k == 0) chk("req_ready_idle", o_req_ready, 1'b1);
            if (prev_awv && !axi.m_axi_awvalid && !aw_d) drop = 1;
            if (prev_wv  && !axi.m_axi_wvalid  && !w_d)  drop = 1;
            if (prev_arv && !axi.m_axi_arvalid && !ar_d) drop = 1;
            if (axi.m_axi_awvalid && axi.m_axi_awready) begin
                n_aw++; aw_d = 1; got_awaddr = axi.m_axi_awaddr;
            end
            if (axi.m_axi_wvalid && axi.m_axi_wready) begin
                n_w++; w_d = 1; got_wdata = axi.m_axi_wdata; got_wstrb = axi.m_axi_wstrb;
            end
            if (axi.m_axi_bvalid && axi.m_axi_bready) begin n_b++; b_d = 1; end
            if (axi.m_axi_arvalid && axi.m_axi_arready) begin
                n_ar++; ar_d = 1; got_araddr = axi.m_axi_araddr;
            end
            if (axi.m_axi_rvalid && axi.m_axi_rready) begin n_r++; r_d = 1; end
            if (o_rsp_valid) begin
                n_rsp++;
                if (n_rsp == 1) begin
                    rsp_k = k; got_rdata = o_rsp_rdata; got_resp = o_rsp_resp;
                    got_tmo = o_rsp_timeout; bready_rsp = axi.m_axi_bready;
                end
            end
            if (rst_at >= 0 && k == rst_at + 1) begin
                chk("rst_axi_ctl_zero", {27'h0, axi_ctl()}, 32'h0);
                chk("rst_rsp_valid",    o_rsp_valid, 1'b0);
            end
            if (k == k_end) rdy_end = o_req_ready;
            prev_awv = axi.m_axi_awvalid;
            prev_wv  = axi.m_axi_wvalid;
            prev_arv = axi.m_axi_arvalid;
        end

        if (rst_at >= 0) begin
            chk("rst_no_rsp_pulse", n_rsp, 0);
        end else begin
            chk("rsp_cycle",       rsp_k, exp_rsp);
            chk("rsp_pulse_count", n_rsp, 1);
            chk("ready_after_rsp", rdy_end, 1'b1);
            chk("rsp_timeout",     got_tmo, exp_tmo);
            chk("rsp_resp",        got_resp, exp_tmo ? 2'b10 : resp);
            chk("rsp_rdata",       got_rdata, (wr || exp_tmo) ? 32'h0 : rdata);
            chk("valid_no_early_drop", drop, 1'b0);
            if (exp_tmo) begin
                chk("tmo_bready_dropped", bready_rsp, 1'b0);
                chk("tmo_no_b_hs", n_b, 0);
            end else if (wr) begin
                chk("aw_hs_count", n_aw, 1);
                chk("w_hs_count",  n_w,  1);
                chk("b_hs_count",  n_b,  1);
                chk("awaddr",      got_awaddr, addr);
                chk("wdata",       got_wdata, wdata);
                chk("wstrb",       got_wstrb, 4'hF);
            end else begin
                chk("ar_hs_count", n_ar, 1);
                chk("r_hs_count",  n_r,  1);
                chk("araddr",      got_araddr, addr);
            end
        end

        @(negedge clk);
        i_req_valid = 1'b0;
        i_rst       = 1'b0;
        slave_idle();
    endtask

    initial begin
        i_rst       = 1'b1;
        i_req_valid = 1'b0;
        i_req_wr    = 1'b0;
        i_req_addr  = '0;
        i_req_wdata = '0;
        slave_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_req_ready",  o_req_ready, 1'b0);
        chk("reset_rsp_valid",  o_rsp_valid, 1'b0);
        chk("reset_rsp_rdata",  o_rsp_rdata, 32'h0);
        chk("reset_rsp_resp",   o_rsp_resp, 2'b00);
        chk("reset_rsp_tmo",    o_rsp_timeout, 1'b0);
        chk("reset_axi_ctl",    {27'h0, axi_ctl()}, 32'h0);
        i_rst = 1'b0;
        #1;
        chk("ready_after_release", o_req_ready, 1'b1);

        run_txn(1'b1, 7'h14, 32'h0000_1234, 0, 0, 0, 2'b00, 32'h0, -1, 1'b0);
        run_txn(1'b1, 7'h20, 32'hA5A5_0F0F, 6, 1, 0, 2'b01, 32'h0, -1, 1'b0);
        run_txn(1'b0, 7'h08, 32'h0, 5, 0, 0, 2'b00, 32'hDEAD_BEEF, -1, 1'b0);
        run_txn(1'b0, 7'h0C, 32'h0, 0, 0, 100000, 2'b00, 32'h1111_2222, 4, 1'b0);
        run_txn(1'b0, 7'h0C, 32'h0, 0, 0, 0, 2'b00, 32'h3333_4444, -1, 1'b0);
`ifdef INTL_AXIM_TIMEOUT_EN
        run_txn(1'b1, 7'h10, 32'hCAFE_F00D, 0, 0, 100000, 2'b00, 32'h0, -1, 1'b1);
        run_txn(1'b0, 7'h18, 32'h0, 0, 0, 0, 2'b11, 32'h5555_AAAA, -1, 1'b0);
`endif
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(0, 1)), 7'($urandom), $urandom,
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 9)), 2'($urandom), $urandom, -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
